// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD rectangle-fill controller.
//   CMD_*        : panel command bytes issued by the draw sequencer
//   *_DEF        : default panel geometry and pixel-counter width
//   state_t      : draw sequencer state encoding
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int unsigned H_RES_DEF = 240;
    localparam int unsigned V_RES_DEF = 320;
    localparam int unsigned CNT_W_DEF = 17;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        StIdle    = 4'd0,
        StCasetC  = 4'd1,
        StCasetD0 = 4'd2,
        StCasetD1 = 4'd3,
        StPasetC  = 4'd4,
        StPasetD0 = 4'd5,
        StPasetD1 = 4'd6,
        StRamwrC  = 4'd7,
        StPix     = 4'd8,
        StFin     = 4'd9
    } state_t;

endpackage

// File: rtl/lcd_area_calc.sv
// Pixel-count calculator for a draw request.
// Latches width/height on i_load, then registers their product; o_count is valid
// two cycles after i_load. Subtraction wraps in CNT_W bits.
// Optional: LCD_DRAW_BOUNDS_CHECK_EN enables the combinational o_reject check on the
// raw request coordinates; without it o_reject is 0.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_load               capture the coordinates
//   i_x0/i_x1/i_y0/i_y1  inclusive column/row range of the request
//   o_count              (x1-x0+1)*(y1-y0+1) truncated to CNT_W bits
//   o_reject             request out of range or inverted
module lcd_area_calc
    import lcd_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEF,
    parameter int unsigned V_RES = V_RES_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [15:0]      i_x0,
    input  logic [15:0]      i_x1,
    input  logic [15:0]      i_y0,
    input  logic [15:0]      i_y1,
    output logic [CNT_W-1:0] o_count,
    output logic             o_reject
);

    // A full-screen fill must fit in the pixel counter without wrapping.
    if ((longint'(1) << CNT_W) < (longint'(H_RES) * longint'(V_RES))) begin : g_cnt_w_too_small
        $error("lcd_area_calc: CNT_W too narrow for H_RES*V_RES");
    end

    logic [CNT_W-1:0] w_q, h_q, count_q;
    logic [CNT_W-1:0] w_d, h_d;

    assign w_d = CNT_W'(i_x1) - CNT_W'(i_x0) + CNT_W'(1);
    assign h_d = CNT_W'(i_y1) - CNT_W'(i_y0) + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_q     <= '0;
            h_q     <= '0;
            count_q <= '0;
        end else begin
            if (i_load) begin
                w_q <= w_d;
                h_q <= h_d;
            end
            // Only the low CNT_W bits of the product are needed.
            count_q <= w_q * h_q;
        end
    end

    assign o_count = count_q;

`ifdef LCD_DRAW_BOUNDS_CHECK_EN
    assign o_reject = (i_x1 < i_x0) || (i_y1 < i_y0) ||
                      (32'(i_x1) >= H_RES) || (32'(i_y1) >= V_RES);
`else
    assign o_reject = 1'b0;
`endif

endmodule

// File: rtl/lcd_draw_ctrl.sv
// Rectangle fill sequencer for an SPI LCD. After panel init is done, a request
// issues CASET+x0,x1, PASET+y0,y1, RAMWR, then the fill colour once per pixel,
// driving the shared command and data serializers one transfer at a time.
// Optional: LCD_DRAW_BOUNDS_CHECK_EN rejects inverted/off-panel rectangles with
// an o_err pulse; without it coordinates are sent raw and o_err is 0.
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_init_done                panel init finished (level)
//   i_req, i_x0..i_y1, i_color draw request, sampled only while idle
//   o_busy, o_done, o_err      status: busy level, done/reject pulses
//   o_dc                       0 = command phase, 1 = data phase
//   o_cmd, o_we_cmd, i_done_cmd    command serializer handshake
//   o_data, o_we_data, i_done_data data serializer handshake
//   o_need_delay               post-command delay request, unused here (0)
module lcd_draw_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEF,
    parameter int unsigned V_RES = V_RES_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_init_done,
    input  logic        i_req,
    input  logic [15:0] i_x0,
    input  logic [15:0] i_x1,
    input  logic [15:0] i_y0,
    input  logic [15:0] i_y1,
    input  logic [15:0] i_color,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_dc,
    output logic [7:0]  o_cmd,
    output logic        o_we_cmd,
    output logic        o_need_delay,
    input  logic        i_done_cmd,
    output logic [15:0] o_data,
    output logic        o_we_data,
    input  logic        i_done_data
);

    state_t state_q, state_d;
    logic [15:0] x0_q, x1_q, y0_q, y1_q, color_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic we_cmd_q, we_cmd_d, we_data_q, we_data_d;
    logic accept, reject;
    logic [CNT_W-1:0] area_count;

    lcd_area_calc #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .CNT_W (CNT_W)
    ) u_area_calc (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (accept),
        .i_x0     (i_x0),
        .i_x1     (i_x1),
        .i_y0     (i_y0),
        .i_y1     (i_y1),
        .o_count  (area_count),
        .o_reject (reject)
    );

    assign accept = (state_q == StIdle) && i_req && i_init_done && !reject;

    // Strobes are registered: a transition into a send state raises the
    // matching o_we_* for exactly the first cycle in that state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_cmd_d  = 1'b0;
        we_data_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StCasetC;
                    we_cmd_d = 1'b1;
                end
            end
            StCasetC: if (i_done_cmd) begin
                state_d   = StCasetD0;
                we_data_d = 1'b1;
            end
            StCasetD0: if (i_done_data) begin
                state_d   = StCasetD1;
                we_data_d = 1'b1;
            end
            StCasetD1: if (i_done_data) begin
                state_d  = StPasetC;
                we_cmd_d = 1'b1;
            end
            StPasetC: if (i_done_cmd) begin
                state_d   = StPasetD0;
                we_data_d = 1'b1;
            end
            StPasetD0: if (i_done_data) begin
                state_d   = StPasetD1;
                we_data_d = 1'b1;
            end
            StPasetD1: if (i_done_data) begin
                state_d  = StRamwrC;
                we_cmd_d = 1'b1;
            end
            StRamwrC: if (i_done_cmd) begin
                state_d   = StPix;
                we_data_d = 1'b1;
                cnt_d     = area_count;
            end
            StPix: if (i_done_data) begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFin;
                end else begin
                    we_data_d = 1'b1;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            we_cmd_q  <= 1'b0;
            we_data_q <= 1'b0;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            color_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_cmd_q  <= we_cmd_d;
            we_data_q <= we_data_d;
            if (accept) begin
                x0_q    <= i_x0;
                x1_q    <= i_x1;
                y0_q    <= i_y0;
                y1_q    <= i_y1;
                color_q <= i_color;
            end
        end
    end

`ifdef LCD_DRAW_BOUNDS_CHECK_EN
    logic err_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == StIdle) && i_req && i_init_done && reject;
        end
    end
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    // Payload and phase follow the state, so they stay stable until the done pulse.
    always_comb begin
        o_cmd  = '0;
        o_data = '0;
        o_dc   = 1'b0;
        case (state_q)
            StCasetC:  o_cmd = CMD_CASET;
            StPasetC:  o_cmd = CMD_PASET;
            StRamwrC:  o_cmd = CMD_RAMWR;
            StCasetD0: begin o_dc = 1'b1; o_data = x0_q;    end
            StCasetD1: begin o_dc = 1'b1; o_data = x1_q;    end
            StPasetD0: begin o_dc = 1'b1; o_data = y0_q;    end
            StPasetD1: begin o_dc = 1'b1; o_data = y1_q;    end
            StPix:     begin o_dc = 1'b1; o_data = color_q; end
            default:   ;
        endcase
    end

    assign o_busy       = (state_q != StIdle) && (state_q != StFin);
    assign o_done       = (state_q == StFin);
    assign o_we_cmd     = we_cmd_q;
    assign o_we_data    = we_data_q;
    assign o_need_delay = 1'b0;

endmodule
